// File: rtl/axi_pkg.sv
// AXI response encodings shared by the AXI-Lite interface and register slave.
package axi_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle (no PROT/cache sideband) with master and slave views.
interface AXI_LITE #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import axi_pkg::*;

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] aw_addr;
    logic                  aw_valid;
    logic                  aw_ready;

    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  w_valid;
    logic                  w_ready;

    resp_t                 b_resp;
    logic                  b_valid;
    logic                  b_ready;

    logic [ADDR_WIDTH-1:0] ar_addr;
    logic                  ar_valid;
    logic                  ar_ready;

    logic [DATA_WIDTH-1:0] r_data;
    resp_t                 r_resp;
    logic                  r_valid;
    logic                  r_ready;

    modport Master (
        output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );

    modport Slave (
        input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );

endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register file: NUM_REGS word registers, each read-write or read-only
// (RO_MASK), with independent read and write FSMs and per-register access pulses.
module axi_lite_reg_slave
    import axi_pkg::*;
#(
    parameter int                      ADDR_WIDTH = -1,
    parameter int                      DATA_WIDTH = 32,
    parameter int                      NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
    parameter logic [NUM_REGS-1:0]     RO_MASK    = '0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    AXI_LITE.Slave                               slv,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  reg_q_o,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  reg_d_i,
    output logic [NUM_REGS-1:0]                  wr_pulse_o,
    output logic [NUM_REGS-1:0]                  rd_pulse_o
);

    localparam int AW         = (ADDR_WIDTH > 0) ? ADDR_WIDTH : 1;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF_BITS   = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [AW-1:0] NUM_REGS_A = AW'(NUM_REGS);

    typedef struct packed {
        logic                 hit;
        logic [IDX_WIDTH-1:0] idx;
    } dec_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } w_state_t;

    // The unsigned subtraction wraps for addresses below BASE_ADDR, so the
    // explicit lower-bound compare is what rejects them.
    function automatic dec_t decode(input logic [AW-1:0] addr);
        logic [AW-1:0] slot;
        dec_t          d;
        slot  = (addr - BASE_ADDR) >> OFF_BITS;
        d.hit = (addr >= BASE_ADDR) && (slot < NUM_REGS_A);
        d.idx = slot[IDX_WIDTH-1:0];
        return d;
    endfunction

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    r_state_t              r_state_reg, r_state_next;
    logic [DATA_WIDTH-1:0] r_data_reg, r_data_next;
    resp_t                 r_resp_reg, r_resp_next;
    dec_t                  rd_dec;

    w_state_t              w_state_reg, w_state_next;
    logic [AW-1:0]         aw_addr_reg, aw_addr_next;
    logic [DATA_WIDTH-1:0] w_data_reg, w_data_next;
    logic [STRB_WIDTH-1:0] w_strb_reg, w_strb_next;
    resp_t                 b_resp_reg, b_resp_next;
    logic [NUM_REGS-1:0]   wr_pulse_reg, wr_pulse_next;

    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    dec_t                  wr_dec;
    logic                  wr_fire;
    logic                  wr_commit;
    logic [NUM_REGS-1:0]   wr_sel;

    // ---------------- read path ----------------
    assign rd_dec = decode(slv.ar_addr);

    always_comb begin
        r_state_next = r_state_reg;
        r_data_next  = r_data_reg;
        r_resp_next  = r_resp_reg;
        slv.ar_ready = 1'b0;
        rd_pulse_o   = '0;
        case (r_state_reg)
            R_IDLE: begin
                slv.ar_ready = 1'b1;
                if (slv.ar_valid) begin
                    r_state_next = R_RESP;
                    if (rd_dec.hit) begin
                        r_data_next            = RO_MASK[rd_dec.idx] ? reg_d_i[rd_dec.idx]
                                                                     : regs_q[rd_dec.idx];
                        r_resp_next            = RESP_OKAY;
                        rd_pulse_o[rd_dec.idx] = 1'b1;
                    end else begin
                        r_data_next = '0;
                        r_resp_next = RESP_DECERR;
                    end
                end
            end
            R_RESP: begin
                if (slv.r_ready) begin
                    r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_reg <= R_IDLE;
            r_data_reg  <= '0;
            r_resp_reg  <= RESP_OKAY;
        end else begin
            r_state_reg <= r_state_next;
            r_data_reg  <= r_data_next;
            r_resp_reg  <= r_resp_next;
        end
    end

    assign slv.r_valid = (r_state_reg == R_RESP);
    assign slv.r_data  = r_data_reg;
    assign slv.r_resp  = r_resp_reg;

    // ---------------- write path ----------------
    // The completing beat is taken live from the bus; the earlier one from its latch.
    assign wr_addr = (w_state_reg == W_HAVE_AW) ? aw_addr_reg : slv.aw_addr;
    assign wr_data = (w_state_reg == W_HAVE_W)  ? w_data_reg  : slv.w_data;
    assign wr_strb = (w_state_reg == W_HAVE_W)  ? w_strb_reg  : slv.w_strb;
    assign wr_dec  = decode(wr_addr);

    always_comb begin
        w_state_next  = w_state_reg;
        aw_addr_next  = aw_addr_reg;
        w_data_next   = w_data_reg;
        w_strb_next   = w_strb_reg;
        b_resp_next   = b_resp_reg;
        wr_pulse_next = '0;
        slv.aw_ready  = 1'b0;
        slv.w_ready   = 1'b0;
        wr_fire       = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                slv.aw_ready = 1'b1;
                slv.w_ready  = 1'b1;
                if (slv.aw_valid && slv.w_valid) begin
                    wr_fire = 1'b1;
                end else if (slv.aw_valid) begin
                    aw_addr_next = slv.aw_addr;
                    w_state_next = W_HAVE_AW;
                end else if (slv.w_valid) begin
                    w_data_next  = slv.w_data;
                    w_strb_next  = slv.w_strb;
                    w_state_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                slv.w_ready = 1'b1;
                wr_fire     = slv.w_valid;
            end
            W_HAVE_W: begin
                slv.aw_ready = 1'b1;
                wr_fire      = slv.aw_valid;
            end
            W_RESP: begin
                if (slv.b_ready) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase

        if (wr_fire) begin
            w_state_next = W_RESP;
            if (!wr_dec.hit) begin
                b_resp_next = RESP_DECERR;
            end else if (RO_MASK[wr_dec.idx]) begin
                b_resp_next = RESP_SLVERR;
            end else begin
                b_resp_next               = RESP_OKAY;
                wr_pulse_next[wr_dec.idx] = 1'b1;
            end
        end
    end

    assign wr_commit = wr_fire && wr_dec.hit && !RO_MASK[wr_dec.idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_reg  <= W_IDLE;
            aw_addr_reg  <= '0;
            w_data_reg   <= '0;
            w_strb_reg   <= '0;
            b_resp_reg   <= RESP_OKAY;
            wr_pulse_reg <= '0;
        end else begin
            w_state_reg  <= w_state_next;
            aw_addr_reg  <= aw_addr_next;
            w_data_reg   <= w_data_next;
            w_strb_reg   <= w_strb_next;
            b_resp_reg   <= b_resp_next;
            wr_pulse_reg <= wr_pulse_next;
        end
    end

    assign slv.b_valid = (w_state_reg == W_RESP);
    assign slv.b_resp  = b_resp_reg;
    assign wr_pulse_o  = wr_pulse_reg;

    // ---------------- register storage ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign wr_sel[gi] = wr_commit && (wr_dec.idx == IDX_WIDTH'(gi));

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    regs_q[gi] <= '0;
                end else if (wr_sel[gi]) begin
                    for (int b = 0; b < STRB_WIDTH; b++) begin
                        if (wr_strb[b]) begin
                            regs_q[gi][b*8 +: 8] <= wr_data[b*8 +: 8];
                        end
                    end
                end
            end

            assign reg_q_o[gi] = regs_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed testbench for axi_lite_reg_slave: 4 registers at 0x100, register 2 read-only.
module tb_axi_lite_reg_slave;
    import axi_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    AXI_LITE #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic [NR-1:0][DW-1:0] reg_q;
    logic [NR-1:0][DW-1:0] reg_d;
    logic [NR-1:0]         wr_pulse;
    logic [NR-1:0]         rd_pulse;

    axi_lite_reg_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .BASE_ADDR  (16'h0100),
        .RO_MASK    (4'b0100)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv        (bus),
        .reg_q_o    (reg_q),
        .reg_d_i    (reg_d),
        .wr_pulse_o (wr_pulse),
        .rd_pulse_o (rd_pulse)
    );

    int checks = 0;
    int passes = 0;

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, output resp_t resp,
                            output logic [NR-1:0] pulse, output int lat);
        bit aw_pend, w_pend, aw_hs, w_hs;
        int n;
        @(posedge clk); #1;
        bus.aw_addr = addr; bus.aw_valid = 1'b1;
        bus.w_data = data; bus.w_strb = strb; bus.w_valid = 1'b1;
        bus.b_ready = 1'b1;
        aw_pend = 1'b1; w_pend = 1'b1; n = 0;
        while ((aw_pend || w_pend) && n < 20) begin
            @(negedge clk);
            aw_hs = bus.aw_valid && bus.aw_ready;
            w_hs  = bus.w_valid && bus.w_ready;
            @(posedge clk); #1;
            if (aw_hs) begin bus.aw_valid = 1'b0; aw_pend = 1'b0; end
            if (w_hs)  begin bus.w_valid  = 1'b0; w_pend  = 1'b0; end
            n++;
        end
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bus.b_valid && lat < 20) begin @(negedge clk); lat++; end
        resp = bus.b_resp; pulse = wr_pulse;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                           output resp_t resp, output logic [NR-1:0] pulse, output int lat);
        bit hs;
        int n;
        @(posedge clk); #1;
        bus.ar_addr = addr; bus.ar_valid = 1'b1; bus.r_ready = 1'b1;
        hs = 1'b0; n = 0; pulse = '0;
        while (!hs && n < 20) begin
            @(negedge clk);
            hs = bus.ar_ready;
            pulse = rd_pulse;
            @(posedge clk); #1;
            n++;
        end
        bus.ar_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bus.r_valid && lat < 20) begin @(negedge clk); lat++; end
        data = bus.r_data; resp = bus.r_resp;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.r_valid, bus.b_valid, bus.r_data, bus.r_resp, bus.b_resp} !== '0)
            $display("FAIL reset_outputs: got rv=%b bv=%b rdata=%h rresp=%h bresp=%h required all zero",
                     bus.r_valid, bus.b_valid, bus.r_data, bus.r_resp, bus.b_resp);
        else passes++;
        checks++;
        if (reg_q !== '0) $display("FAIL reset_regs: got %h required 0", reg_q);
        else passes++;
        checks++;
        if ({wr_pulse, rd_pulse} !== '0)
            $display("FAIL reset_pulses: got wr=%b rd=%b required 0", wr_pulse, rd_pulse);
        else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.ar_ready, bus.aw_ready, bus.w_ready} !== 3'b111)
            $display("FAIL ready_after_reset: got %b required 111", {bus.ar_ready, bus.aw_ready, bus.w_ready});
        else passes++;
    endtask

    task automatic test_write_basic;
        @(posedge clk); #1;
        bus.aw_addr = 16'h0100; bus.aw_valid = 1'b1;
        bus.w_data = 32'hDEADBEEF; bus.w_strb = 4'hF; bus.w_valid = 1'b1; bus.b_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.b_valid !== 1'b0) $display("FAIL wb_no_early_b: got %b required 0", bus.b_valid);
        else passes++;
        @(posedge clk); #1;
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.b_valid !== 1'b1 || bus.b_resp !== RESP_OKAY)
            $display("FAIL wb_resp: got bv=%b resp=%h required 1/0", bus.b_valid, bus.b_resp);
        else passes++;
        checks++;
        if (reg_q[0] !== 32'hDEADBEEF) $display("FAIL wb_reg0: got %h required deadbeef", reg_q[0]);
        else passes++;
        checks++;
        if (wr_pulse !== 4'b0001) $display("FAIL wb_pulse_on: got %b required 0001", wr_pulse);
        else passes++;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (wr_pulse !== 4'b0000 || bus.b_valid !== 1'b0)
            $display("FAIL wb_pulse_off: got pulse=%b bv=%b required 0000/0", wr_pulse, bus.b_valid);
        else passes++;
    endtask

    task automatic test_w_before_aw;
        resp_t resp; logic [NR-1:0] pulse; int lat;
        do_write(16'h0104, 32'hAABBCCDD, 4'hF, resp, pulse, lat);
        checks++;
        if (resp !== RESP_OKAY || reg_q[1] !== 32'hAABBCCDD || lat !== 0)
            $display("FAIL pw_setup: got resp=%h reg1=%h lat=%0d required 0/aabbccdd/0", resp, reg_q[1], lat);
        else passes++;
        @(posedge clk); #1;
        bus.w_data = 32'h12345678; bus.w_strb = 4'b0011; bus.w_valid = 1'b1; bus.b_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.w_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({bus.aw_ready, bus.w_ready, bus.b_valid} !== 3'b100 || reg_q[1] !== 32'hAABBCCDD)
                $display("FAIL pw_wait: got awr/wr/bv=%b reg1=%h required 100/aabbccdd",
                         {bus.aw_ready, bus.w_ready, bus.b_valid}, reg_q[1]);
            else passes++;
            @(posedge clk); #1;
        end
        bus.aw_addr = 16'h0104; bus.aw_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.b_valid !== 1'b1 || bus.b_resp !== RESP_OKAY || wr_pulse !== 4'b0010)
            $display("FAIL pw_resp: got bv=%b resp=%h pulse=%b required 1/0/0010", bus.b_valid, bus.b_resp, wr_pulse);
        else passes++;
        checks++;
        if (reg_q[1] !== 32'hAABB5678) $display("FAIL pw_data: got %h required aabb5678", reg_q[1]);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_strobe;
        resp_t resp; logic [NR-1:0] pulse; int lat;
        do_write(16'h0104, 32'hFFFFFFFF, 4'h0, resp, pulse, lat);
        checks++;
        if (resp !== RESP_OKAY || pulse !== 4'b0010 || reg_q[1] !== 32'hAABB5678)
            $display("FAIL zero_strb: got resp=%h pulse=%b reg1=%h required 0/0010/aabb5678", resp, pulse, reg_q[1]);
        else passes++;
    endtask

    task automatic test_read_only;
        resp_t resp; logic [NR-1:0] pulse; logic [DW-1:0] data; int lat;
        do_read(16'h0108, data, resp, pulse, lat);
        checks++;
        if (data !== 32'hCAFE0000 || resp !== RESP_OKAY || pulse !== 4'b0100 || lat !== 0)
            $display("FAIL ro_read: got data=%h resp=%h rdpulse=%b lat=%0d required cafe0000/0/0100/0",
                     data, resp, pulse, lat);
        else passes++;
        do_write(16'h0108, 32'h11111111, 4'hF, resp, pulse, lat);
        checks++;
        if (resp !== RESP_SLVERR || pulse !== 4'b0000 || reg_q[2] !== 32'h0)
            $display("FAIL ro_write: got resp=%h pulse=%b reg2=%h required 2/0000/0", resp, pulse, reg_q[2]);
        else passes++;
    endtask

    task automatic test_decerr;
        resp_t resp; logic [NR-1:0] pulse; logic [DW-1:0] data; int lat;
        do_read(16'h0110, data, resp, pulse, lat);
        checks++;
        if (data !== 32'h0 || resp !== RESP_DECERR || pulse !== 4'b0000)
            $display("FAIL dec_read_high: got data=%h resp=%h rdpulse=%b required 0/3/0000", data, resp, pulse);
        else passes++;
        do_read(16'h00FC, data, resp, pulse, lat);
        checks++;
        if (data !== 32'h0 || resp !== RESP_DECERR || pulse !== 4'b0000)
            $display("FAIL dec_read_low: got data=%h resp=%h rdpulse=%b required 0/3/0000", data, resp, pulse);
        else passes++;
        do_write(16'h0110, 32'hFFFFFFFF, 4'hF, resp, pulse, lat);
        checks++;
        if (resp !== RESP_DECERR || pulse !== 4'b0000 ||
            reg_q !== {32'h0, 32'h0, 32'hAABB5678, 32'hDEADBEEF})
            $display("FAIL dec_write: got resp=%h pulse=%b regs=%h required 3/0000/0..aabb5678deadbeef",
                     resp, pulse, reg_q);
        else passes++;
    endtask

    task automatic test_decode;
        resp_t resp; logic [NR-1:0] pulse; logic [DW-1:0] data; int lat;
        do_read(16'h0103, data, resp, pulse, lat);
        checks++;
        if (data !== 32'hDEADBEEF || resp !== RESP_OKAY || pulse !== 4'b0001)
            $display("FAIL dec_byte_offset: got data=%h resp=%h rdpulse=%b required deadbeef/0/0001", data, resp, pulse);
        else passes++;
        do_read(16'h010C, data, resp, pulse, lat);
        checks++;
        if (data !== 32'h0 || resp !== RESP_OKAY || pulse !== 4'b1000)
            $display("FAIL dec_last_reg: got data=%h resp=%h rdpulse=%b required 0/0/1000", data, resp, pulse);
        else passes++;
        do_write(16'h010E, 32'h00000055, 4'b0001, resp, pulse, lat);
        checks++;
        if (resp !== RESP_OKAY || pulse !== 4'b1000 || reg_q[3] !== 32'h00000055)
            $display("FAIL dec_write_offset: got resp=%h pulse=%b reg3=%h required 0/1000/55", resp, pulse, reg_q[3]);
        else passes++;
    endtask

    task automatic test_stall;
        @(posedge clk); #1;
        bus.ar_addr = 16'h0100; bus.ar_valid = 1'b1; bus.r_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.r_valid !== 1'b1 || bus.r_data !== 32'hDEADBEEF || bus.ar_ready !== 1'b0)
                $display("FAIL r_stall[%0d]: got rv=%b data=%h arr=%b required 1/deadbeef/0",
                         i, bus.r_valid, bus.r_data, bus.ar_ready);
            else passes++;
            @(posedge clk); #1;
        end
        bus.r_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.r_valid !== 1'b0 || bus.ar_ready !== 1'b1)
            $display("FAIL r_stall_release: got rv=%b arr=%b required 0/1", bus.r_valid, bus.ar_ready);
        else passes++;

        @(posedge clk); #1;
        bus.aw_addr = 16'h010C; bus.aw_valid = 1'b1;
        bus.w_data = 32'h00000077; bus.w_strb = 4'hF; bus.w_valid = 1'b1; bus.b_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.b_valid !== 1'b1 || bus.b_resp !== RESP_OKAY || bus.aw_ready !== 1'b0 ||
                bus.w_ready !== 1'b0 || wr_pulse !== ((i == 0) ? 4'b1000 : 4'b0000))
                $display("FAIL b_stall[%0d]: got bv=%b resp=%h awr=%b wr=%b pulse=%b", i,
                         bus.b_valid, bus.b_resp, bus.aw_ready, bus.w_ready, wr_pulse);
            else passes++;
            @(posedge clk); #1;
        end
        bus.b_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.b_valid !== 1'b0 || bus.aw_ready !== 1'b1 || reg_q[3] !== 32'h00000077)
            $display("FAIL b_stall_release: got bv=%b awr=%b reg3=%h required 0/1/77",
                     bus.b_valid, bus.aw_ready, reg_q[3]);
        else passes++;
    endtask

    task automatic test_collision;
        resp_t resp; logic [NR-1:0] pulse; logic [DW-1:0] data; int lat;
        do_write(16'h0100, 32'h1, 4'hF, resp, pulse, lat);
        @(posedge clk); #1;
        bus.ar_addr = 16'h0100; bus.ar_valid = 1'b1; bus.r_ready = 1'b1;
        bus.aw_addr = 16'h0100; bus.aw_valid = 1'b1;
        bus.w_data = 32'h2; bus.w_strb = 4'hF; bus.w_valid = 1'b1; bus.b_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.ar_valid = 1'b0; bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.r_valid !== 1'b1 || bus.r_data !== 32'h1)
            $display("FAIL coll_read_old: got rv=%b data=%h required 1/00000001", bus.r_valid, bus.r_data);
        else passes++;
        checks++;
        if (bus.b_valid !== 1'b1 || bus.b_resp !== RESP_OKAY || reg_q[0] !== 32'h2)
            $display("FAIL coll_write_new: got bv=%b resp=%h reg0=%h required 1/0/00000002",
                     bus.b_valid, bus.b_resp, reg_q[0]);
        else passes++;
        @(posedge clk); #1;
        do_read(16'h0100, data, resp, pulse, lat);
        checks++;
        if (data !== 32'h2 || resp !== RESP_OKAY)
            $display("FAIL coll_read_new: got data=%h resp=%h required 00000002/0", data, resp);
        else passes++;
    endtask

    task automatic test_back_to_back;
        int ar_cnt, w_cnt;
        logic [DW-1:0] last_r;
        ar_cnt = 0; w_cnt = 0; last_r = '0;
        @(posedge clk); #1;
        bus.ar_addr = 16'h0104; bus.ar_valid = 1'b1; bus.r_ready = 1'b1;
        bus.aw_addr = 16'h010C; bus.aw_valid = 1'b1;
        bus.w_data = 32'h00000099; bus.w_strb = 4'hF; bus.w_valid = 1'b1; bus.b_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.ar_valid && bus.ar_ready) ar_cnt++;
            if (bus.aw_valid && bus.aw_ready && bus.w_valid && bus.w_ready) w_cnt++;
            if (bus.r_valid) last_r = bus.r_data;
        end
        @(posedge clk); #1;
        bus.ar_valid = 1'b0; bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ar_cnt !== 4 || w_cnt !== 4)
            $display("FAIL b2b_rate: got reads=%0d writes=%0d in 8 cycles required 4/4", ar_cnt, w_cnt);
        else passes++;
        checks++;
        if (last_r !== 32'hAABB5678 || reg_q[3] !== 32'h00000099)
            $display("FAIL b2b_data: got rdata=%h reg3=%h required aabb5678/99", last_r, reg_q[3]);
        else passes++;
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        bus.aw_addr = 16'h0100; bus.aw_valid = 1'b1; bus.b_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.aw_ready, bus.w_ready} !== 2'b01)
            $display("FAIL mid_have_aw: got awr/wr=%b required 01", {bus.aw_ready, bus.w_ready});
        else passes++;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (reg_q !== '0 || bus.b_valid !== 1'b0)
            $display("FAIL mid_reset_clear: got regs=%h bv=%b required 0/0", reg_q, bus.b_valid);
        else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.ar_ready, bus.aw_ready, bus.w_ready} !== 3'b111)
            $display("FAIL mid_ready_after: got %b required 111", {bus.ar_ready, bus.aw_ready, bus.w_ready});
        else passes++;
        bus.w_data = 32'h5A5A5A5A; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
        @(posedge clk); #1;
        bus.w_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.b_valid !== 1'b0 || reg_q[0] !== 32'h0)
                $display("FAIL mid_no_resp[%0d]: got bv=%b reg0=%h required 0/0", i, bus.b_valid, reg_q[0]);
            else passes++;
        end
    endtask

    initial begin
        bus.aw_addr = '0; bus.aw_valid = 1'b0;
        bus.w_data = '0; bus.w_strb = '0; bus.w_valid = 1'b0; bus.b_ready = 1'b1;
        bus.ar_addr = '0; bus.ar_valid = 1'b0; bus.r_ready = 1'b1;
        reg_d = {32'h33333333, 32'hCAFE0000, 32'h11111111, 32'h10101010};

        test_reset;
        test_write_basic;
        test_w_before_aw;
        test_zero_strobe;
        test_read_only;
        test_decerr;
        test_decode;
        test_stall;
        test_collision;
        test_back_to_back;
        test_reset_mid;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
